// File: rtl/riscv_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile_pkg
// Description : Shared CPU constants and types for the RV32I register file.
//               XLEN / REG_AW / NREGS sizing constants, reg_idx_t, word_t.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

endpackage : riscv_regfile_pkg
`default_nettype wire

// File: rtl/riscv_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile_if
// Description : Register-file access bundle between decode/writeback logic
//               (master) and the register file (slave).
//               rr1/rr2 : read indices      rdata1/rdata2 : read data
//               wrr     : write index       wr_en/wrdata  : write enable/data
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_regfile_if;
  import riscv_regfile_pkg::*;

  reg_idx_t rr1;
  reg_idx_t rr2;
  reg_idx_t wrr;
  logic     wr_en;
  word_t    wrdata;
  word_t    rdata1;
  word_t    rdata2;

  modport master (
    output rr1, rr2, wrr, wr_en, wrdata,
    input  rdata1, rdata2
  );

  modport slave (
    input  rr1, rr2, wrr, wr_en, wrdata,
    output rdata1, rdata2
  );

endinterface : riscv_regfile_if
`default_nettype wire

// File: rtl/riscv_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile_rdport
// Description : One combinational read port: register select, x0 masking and
//               optional same-cycle write bypass.
//               rst_n  : forces the output to zero while reset is held
//               rr     : read index        rdata : read data
//               wr_en/wrr/wrdata : the write currently being presented
//               regs   : storage x1..x(NREGS-1)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_regfile_rdport #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic            rst_n,
  input  logic [AW-1:0]   rr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wrr,
  input  logic [XLEN-1:0] wrdata,
  input  logic [XLEN-1:0] regs [1:NREGS-1],
  output logic [XLEN-1:0] rdata
);
  import riscv_regfile_pkg::*;

  logic w_bypass_hit;

  // rr != 0 is checked separately, so a write to x0 can never bypass.
  assign w_bypass_hit = (BYPASS_EN != 0) && wr_en && (wrr == rr);

  always_comb begin
    rdata = '0;
    if (rst_n && (rr != '0)) begin
      if (w_bypass_hit) begin
        rdata = wrdata;
      end else begin
        rdata = regs[rr];
      end
    end
  end

endmodule : riscv_regfile_rdport
`default_nettype wire

// File: rtl/riscv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile
// Description : RV32I integer register file, 32 x 32-bit, two combinational
//               read ports and one write port; x0 hardwired to zero.
//               clk   : rising-edge clock
//               rst_n : asynchronous active-low reset, clears x1..x31
//               bus   : riscv_regfile_if.slave (rr1, rr2, wrr, wr_en,
//                       wrdata in; rdata1, rdata2 out)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_regfile #(
  parameter int XLEN      = riscv_regfile_pkg::XLEN,
  parameter int NREGS     = riscv_regfile_pkg::NREGS,
  parameter int AW        = $clog2(NREGS),
  parameter int BYPASS_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_regfile_if.slave        bus
);
  import riscv_regfile_pkg::*;

  // x0 has no storage; the read ports synthesise its zero.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.wr_en && (bus.wrr != '0)) begin
      r_regs[bus.wrr] <= bus.wrdata;
    end
  end

  riscv_regfile_rdport #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .AW        (AW),
    .BYPASS_EN (BYPASS_EN)
  ) u_rdport1 (
    .rst_n  (rst_n),
    .rr     (bus.rr1),
    .wr_en  (bus.wr_en),
    .wrr    (bus.wrr),
    .wrdata (bus.wrdata),
    .regs   (r_regs),
    .rdata  (bus.rdata1)
  );

  riscv_regfile_rdport #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .AW        (AW),
    .BYPASS_EN (BYPASS_EN)
  ) u_rdport2 (
    .rst_n  (rst_n),
    .rr     (bus.rr2),
    .wr_en  (bus.wr_en),
    .wrr    (bus.wrr),
    .wrdata (bus.wrdata),
    .regs   (r_regs),
    .rdata  (bus.rdata2)
  );

endmodule : riscv_regfile
`default_nettype wire

// File: tb/tb_riscv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_regfile
// Description : Self-checking bench for riscv_regfile (BYPASS_EN=1).
//               Stimulus pushes expected read data into a scoreboard queue;
//               a monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_regfile;
  import riscv_regfile_pkg::*;

  typedef struct {
    string name;
    word_t e1;
    word_t e2;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    errors;
  int    checks;
  exp_t  sb [$];
  word_t model [NREGS];

  riscv_regfile_if bus ();

  riscv_regfile #(
    .BYPASS_EN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so they are presented every cycle;
  // sample on the falling edge, midway between stimulus updates.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rdata1 !== e.e1) begin
        errors++;
        $display("FAIL %s rdata1: got %h expected %h", e.name, bus.rdata1, e.e1);
      end
      checks++;
      if (bus.rdata2 !== e.e2) begin
        errors++;
        $display("FAIL %s rdata2: got %h expected %h", e.name, bus.rdata2, e.e2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input word_t e1, input word_t e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    sb.push_back(e);
  endtask

  task automatic drive(input reg_idx_t r1, input reg_idx_t r2,
                       input logic we, input reg_idx_t wi, input word_t wd);
    bus.rr1    = r1;
    bus.rr2    = r2;
    bus.wr_en  = we;
    bus.wrr    = wi;
    bus.wrdata = wd;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0);

    // Outputs are zero while reset is held, even with a bypassable write.
    step();
    drive(5'd4, 5'd4, 1'b1, 5'd4, 32'h1234_5678);
    expect_rd("reset_held", 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0);

    // 1. Read everything after reset.
    for (int i = 0; i < 16; i++) begin
      drive(reg_idx_t'(2*i), reg_idx_t'(2*i+1), 1'b0, 5'd0, '0);
      expect_rd("reset_sweep", 32'h0, 32'h0);
      step();
    end

    // 2. Write to x0 is discarded, including during the write cycle itself.
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    expect_rd("x0_write_cycle", 32'h0, 32'h0);
    step();
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0);
    expect_rd("x0_after", 32'h0, 32'h0);
    step();

    // 3. Writeback sweep: write then read on the following cycle.
    for (int i = 1; i < NREGS; i++) begin
      word_t v;
      v = $urandom;
      drive(5'd0, 5'd0, 1'b1, reg_idx_t'(i), v);
      step();
      model[i] = v;
      drive(reg_idx_t'(i), reg_idx_t'(NREGS-i), 1'b0, 5'd0, '0);
      expect_rd("wb_sweep", model[i], model[NREGS-i]);
      step();
    end

    // 4. Bypass: both ports see the in-flight write before the edge.
    drive(5'd0, 5'd0, 1'b1, 5'd5, 32'h1111_1111);
    step();
    model[5] = 32'h1111_1111;
    drive(5'd5, 5'd5, 1'b1, 5'd5, 32'h2222_2222);
    expect_rd("bypass", 32'h2222_2222, 32'h2222_2222);
    step();
    model[5] = 32'h2222_2222;
    drive(5'd5, 5'd6, 1'b1, 5'd6, 32'h3333_3333);
    expect_rd("bypass_one_port", 32'h2222_2222, 32'h3333_3333);
    step();
    model[6] = 32'h3333_3333;

    // 5. Disabled write leaves x7 untouched over several edges.
    drive(5'd7, 5'd7, 1'b0, 5'd7, 32'hCAFE_F00D);
    expect_rd("wr_disabled_pre", model[7], model[7]);
    step();
    step();
    step();
    expect_rd("wr_disabled", model[7], model[6]);
    bus.rr2 = 5'd6;
    step();

    // 6. Async reset between edges, with a write pending across the edge.
    drive(5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5);
    step();
    model[3] = 32'hA5A5_A5A5;
    drive(5'd3, 5'd5, 1'b0, 5'd0, '0);
    expect_rd("pre_reset", 32'hA5A5_A5A5, model[5]);
    step();
    drive(5'd3, 5'd5, 1'b1, 5'd9, 32'h9999_9999);
    rst_n = 1'b0;
    expect_rd("async_reset", 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    drive(5'd3, 5'd9, 1'b0, 5'd0, '0);
    expect_rd("post_reset", 32'h0, 32'h0);
    step();
    drive(5'd5, 5'd31, 1'b0, 5'd0, '0);
    expect_rd("post_reset2", 32'h0, 32'h0);
    step();

    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule : tb_riscv_regfile
`default_nettype wire
